// File: rtl/tmr_line_receiver_pkg.sv
// Shared types, default parameters and voting helpers for the triple-redundant line receiver.
package tmr_line_receiver_pkg;

  typedef enum logic [1:0] {
    SETTLE   = 2'd0,
    TRACK    = 2'd1,
    DEGRADED = 2'd2
  } rx_state_e;

  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_FILTER_LEN    = 4;
  localparam int unsigned DEF_DEGRADE_LIMIT = 16;
  localparam int unsigned DEF_ERR_W         = 8;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // One-hot flag of the single line that disagrees with the majority (zero when all agree).
  function automatic logic [2:0] minority_onehot(input logic [2:0] v);
    return v ^ {3{majority3(v)}};
  endfunction

endpackage

// File: rtl/tmr_line_receiver_sync_vote.sv
// Three-line synchronizer with majority vote, disagreement and minority-line decode.
module tmr_sync_vote
  import tmr_line_receiver_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] line_in,
  output logic       vote,
  output logic       dis,
  output logic [2:0] minority,
  output logic       primed
);

  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0]      fill_q, fill_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = line_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    fill_d = {fill_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= sync_d;
      fill_q <= fill_d;
    end
  end

  // Decoded straight off the last synchronizer flop so the vote adds no pipeline cycle.
  assign vote     = majority3(sync_q[SYNC_STAGES-1]);
  assign minority = minority_onehot(sync_q[SYNC_STAGES-1]);
  assign dis      = |minority;
  assign primed   = fill_q[SYNC_STAGES-1];

endmodule

// File: rtl/tmr_line_receiver.sv
// Receive end of the triple-redundant link: sync, vote, deglitch, fault tracking.
// Optional saturating error counter enabled by defining TMR_RX_ERR_CNT_EN.
module tmr_line_receiver
  import tmr_line_receiver_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned FILTER_LEN    = DEF_FILTER_LEN,
  parameter int unsigned DEGRADE_LIMIT = DEF_DEGRADE_LIMIT,
  parameter int unsigned ERR_W         = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [2:0]       line_in,
  input  logic             clr_err,
  output logic             data_out,
  output logic             valid,
  output logic             rise,
  output logic             fall,
  output logic             disagree,
  output logic [2:0]       fault_line,
  output logic [ERR_W-1:0] err_count,
  output logic             degraded
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned RUN_W = $clog2(DEGRADE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(DEGRADE_LIMIT);

  logic       vote, dis, primed;
  logic [2:0] minority;

  tmr_sync_vote #(.SYNC_STAGES(SYNC_STAGES)) u_sync_vote (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_in  (line_in),
    .vote     (vote),
    .dis      (dis),
    .minority (minority),
    .primed   (primed)
  );

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [2:0]       fault_q, fault_d;
  logic             cand_q, cand_d;
  logic             data_q, data_d;
  logic             valid_q, valid_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             disagree_q, disagree_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    run_d      = run_q;
    fault_d    = fault_q;
    cand_d     = cand_q;
    data_d     = data_q;
    valid_d    = valid_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    disagree_d = dis;

    if (ena) begin
      if (!dis) begin
        run_d = '0;
      end else if (run_q != RUN_LIMIT) begin
        run_d = run_q + RUN_W'(1);
      end
      if (dis) begin
        fault_d = fault_q | minority;
      end

      case (state_q)
        // cand_q holds the value whose stability is being timed; cnt_q==0 means no history yet.
        SETTLE: begin
          if (!primed) begin
            cnt_d = '0;
          end else if (cnt_q != '0 && vote != cand_q) begin
            cand_d = vote;
            cnt_d  = CNT_W'(1);
          end else if (cnt_q == FILT_LAST) begin
            data_d  = vote;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = TRACK;
          end else begin
            cand_d = vote;
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
        TRACK, DEGRADED: begin
          if (vote == data_q) begin
            cnt_d = '0;
          end else if (cnt_q == FILT_LAST) begin
            data_d = vote;
            cnt_d  = '0;
            rise_d = vote;
            fall_d = !vote;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = SETTLE;
      endcase

      if (state_q == TRACK && run_d == RUN_LIMIT) begin
        state_d = DEGRADED;
      end
      if (state_q == DEGRADED && clr_err) begin
        if (dis) begin
          run_d = '0;
        end else begin
          state_d = TRACK;
        end
      end
      if (clr_err) begin
        fault_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SETTLE;
      cnt_q      <= '0;
      run_q      <= '0;
      fault_q    <= '0;
      cand_q     <= 1'b0;
      data_q     <= 1'b0;
      valid_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      disagree_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      fault_q    <= fault_d;
      cand_q     <= cand_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      disagree_q <= disagree_d;
    end
  end

`ifdef TMR_RX_ERR_CNT_EN
  // Own edge detector, frozen with ena, so an episode starting while disabled still counts on resume.
  logic             dis_prev_q, dis_prev_d;
  logic [ERR_W-1:0] err_q, err_d;

  always_comb begin
    dis_prev_d = dis_prev_q;
    err_d      = err_q;
    if (ena) begin
      dis_prev_d = dis;
      if (clr_err) begin
        err_d = '0;
      end else if (dis && !dis_prev_q && err_q != '1) begin
        err_d = err_q + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dis_prev_q <= 1'b0;
      err_q      <= '0;
    end else begin
      dis_prev_q <= dis_prev_d;
      err_q      <= err_d;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign disagree   = disagree_q;
  assign fault_line = fault_q;
  assign degraded   = (state_q == DEGRADED);

endmodule

// File: tb/tb_tmr_line_receiver.sv
// Self-checking bench for tmr_line_receiver: expected values queued per scenario, popped at sample points.
module tb_tmr_line_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [2:0] line_in;
  logic       clr_err;
  logic       data_out, valid, rise, fall, disagree, degraded;
  logic [2:0] fault_line;
  logic [7:0] err_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  tmr_line_receiver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .line_in    (line_in),
    .clr_err    (clr_err),
    .data_out   (data_out),
    .valid      (valid),
    .rise       (rise),
    .fall       (fall),
    .disagree   (disagree),
    .fault_line (fault_line),
    .err_count  (err_count),
    .degraded   (degraded)
  );

  function automatic logic [31:0] expErr(input int n);
`ifdef TMR_RX_ERR_CNT_EN
    return (n > 255) ? 32'd255 : 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expectVal(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic popCheck(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_empty: got %0d expected nothing", obs);
    end else begin
      e = sb.pop_front();
      checkOutput(e.tag, obs, e.val);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] l, input logic e, input logic c);
    line_in = l;
    ena     = e;
    clr_err = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseClear(input logic [2:0] l);
    applyStimulus(l, 1'b1, 1'b1);
    tick();
    applyStimulus(l, 1'b1, 1'b0);
  endtask

  // Drives 111 for 'hold' cycles then 000, watching data_out over a fixed window.
  task automatic runPulse(input int hold, output int sawHigh, output int rises, output int falls);
    sawHigh = 0;
    rises   = 0;
    falls   = 0;
    applyStimulus(3'b111, 1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == hold) applyStimulus(3'b000, 1'b1, 1'b0);
      if (data_out === 1'b1) sawHigh = 1;
      rises += int'(rise);
      falls += int'(fall);
    end
  endtask

  initial begin
    int pulses, firstHigh, riseAt, rises, falls, sawHigh, changed;

    applyStimulus(3'b000, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    expectVal("rst_data", 0);
    expectVal("rst_valid", 0);
    expectVal("rst_fault", 0);
    expectVal("rst_err", 0);
    expectVal("rst_degraded", 0);
    expectVal("rst_disagree", 0);
    popCheck(32'(data_out));
    popCheck(32'(valid));
    popCheck(32'(fault_line));
    popCheck(32'(err_count));
    popCheck(32'(degraded));
    popCheck(32'(disagree));

    $display("[TB] settle from reset with lines 000");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expectVal("settle_valid_c5", 0);
    expectVal("settle_valid_c6", 1);
    expectVal("settle_data", 0);
    expectVal("settle_pulses", 0);
    expectVal("settle_err", 0);
    pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      pulses += int'(rise) + int'(fall);
      if (i == 5) popCheck(32'(valid));
    end
    popCheck(32'(valid));
    popCheck(32'(data_out));
    popCheck(32'(pulses));
    popCheck(32'(err_count));

    $display("[TB] clean 000->111 latency");
    applyStimulus(3'b111, 1'b1, 1'b0);
    expectVal("lat_first_high", 6);
    expectVal("lat_rise_cycle", 6);
    expectVal("lat_rises", 1);
    expectVal("lat_falls", 0);
    firstHigh = 0;
    riseAt    = 0;
    rises     = 0;
    falls     = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (data_out === 1'b1 && firstHigh == 0) firstHigh = i;
      if (rise === 1'b1 && riseAt == 0) riseAt = i;
      rises += int'(rise);
      falls += int'(fall);
    end
    popCheck(32'(firstHigh));
    popCheck(32'(riseAt));
    popCheck(32'(rises));
    popCheck(32'(falls));
    applyStimulus(3'b000, 1'b1, 1'b0);
    repeat (12) tick();
    expectVal("back_to_zero", 0);
    popCheck(32'(data_out));

    $display("[TB] glitch filter 3 and 4 cycle pulses");
    expectVal("p3_high", 0);
    expectVal("p3_rises", 0);
    runPulse(3, sawHigh, rises, falls);
    popCheck(32'(sawHigh));
    popCheck(32'(rises));
    expectVal("p4_high", 1);
    expectVal("p4_rises", 1);
    expectVal("p4_falls", 1);
    runPulse(4, sawHigh, rises, falls);
    popCheck(32'(sawHigh));
    popCheck(32'(rises));
    popCheck(32'(falls));

    $display("[TB] single faulty line 010");
    applyStimulus(3'b010, 1'b1, 1'b0);
    expectVal("deg_c17", 0);
    expectVal("deg_c18", 1);
    expectVal("flt_data", 0);
    expectVal("flt_fault", 3'b010);
    expectVal("flt_err", expErr(1));
    expectVal("flt_disagree", 1);
    expectVal("flt_degraded", 1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 17 || i == 18) popCheck(32'(degraded));
    end
    popCheck(32'(data_out));
    popCheck(32'(fault_line));
    popCheck(32'(err_count));
    popCheck(32'(disagree));
    popCheck(32'(degraded));
    applyStimulus(3'b000, 1'b1, 1'b0);
    repeat (3) tick();
    expectVal("pre_clr_degraded", 1);
    expectVal("clr_degraded", 0);
    expectVal("clr_fault", 0);
    expectVal("clr_err", 0);
    popCheck(32'(degraded));
    pulseClear(3'b000);
    popCheck(32'(degraded));
    popCheck(32'(fault_line));
    popCheck(32'(err_count));

    $display("[TB] error counter episodes and saturation");
    expectVal("err_after_10", expErr(10));
    expectVal("fault_after_10", 3'b001);
    expectVal("err_after_300", expErr(300));
    expectVal("err_cleared", 0);
    for (int n = 0; n < 10; n++) begin
      applyStimulus(3'b001, 1'b1, 1'b0);
      tick();
      applyStimulus(3'b000, 1'b1, 1'b0);
      tick();
    end
    repeat (3) tick();
    popCheck(32'(err_count));
    popCheck(32'(fault_line));
    for (int n = 0; n < 290; n++) begin
      applyStimulus(3'b001, 1'b1, 1'b0);
      tick();
      applyStimulus(3'b000, 1'b1, 1'b0);
      tick();
    end
    repeat (3) tick();
    popCheck(32'(err_count));
    pulseClear(3'b000);
    popCheck(32'(err_count));

    $display("[TB] enable freeze during disagreement");
    applyStimulus(3'b110, 1'b0, 1'b0);
    expectVal("frz_changes", 0);
    expectVal("frz_pulses", 0);
    changed = 0;
    pulses  = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (data_out !== 1'b0 || err_count !== 8'd0 || fault_line !== 3'b000) changed++;
      pulses += int'(rise) + int'(fall);
    end
    popCheck(32'(changed));
    popCheck(32'(pulses));
    applyStimulus(3'b110, 1'b1, 1'b0);
    expectVal("resume_data_c3", 0);
    expectVal("resume_data_c4", 1);
    expectVal("resume_rise_c4", 1);
    expectVal("resume_fault", 3'b001);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 3) popCheck(32'(data_out));
    end
    popCheck(32'(data_out));
    popCheck(32'(rise));
    popCheck(32'(fault_line));

    $display("[TB] asynchronous reset mid-transition");
    applyStimulus(3'b000, 1'b1, 1'b0);
    repeat (3) tick();
    expectVal("pre_rst_valid", 1);
    expectVal("pre_rst_data", 1);
    popCheck(32'(valid));
    popCheck(32'(data_out));
    rst_n = 1'b0;
    #1;
    expectVal("arst_data", 0);
    expectVal("arst_valid", 0);
    expectVal("arst_rise", 0);
    expectVal("arst_fault", 0);
    expectVal("arst_err", 0);
    expectVal("arst_degraded", 0);
    expectVal("arst_disagree", 0);
    popCheck(32'(data_out));
    popCheck(32'(valid));
    popCheck(32'(rise));
    popCheck(32'(fault_line));
    popCheck(32'(err_count));
    popCheck(32'(degraded));
    popCheck(32'(disagree));

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
